// File: rtl/fb_pkg.sv
// Shared frame-buffer constants: geometry, pixel codes and scheduler states.
package fb_pkg;

  localparam int unsigned FB_X_W   = 10;
  localparam int unsigned FB_Y_W   = 9;
  localparam int unsigned FB_PIX_W = 2;
  localparam int unsigned FB_X_MAX = 639;
  localparam int unsigned FB_Y_MAX = 479;

  localparam logic [1:0] CODE_WHITE   = 2'b00;
  localparam logic [1:0] CODE_TRACE1  = 2'b01;
  localparam logic [1:0] CODE_TRACE2  = 2'b10;
  localparam logic [1:0] CODE_SPECIAL = 2'b11;

  typedef enum logic [0:0] {
    ARB   = 1'b0,
    CLEAR = 1'b1
  } fb_state_e;

  // Plain constants mirror the enum for code that keeps state as raw logic.
  localparam logic [0:0] ST_ARB   = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

endpackage

// File: rtl/fb_clear_counter.sv
// Raster counter for the clear sweep: cy is the inner loop, cx the outer.
module fb_clear_counter
  import fb_pkg::*;
#(
  parameter int unsigned X_W   = FB_X_W,
  parameter int unsigned Y_W   = FB_Y_W,
  parameter int unsigned X_MAX = FB_X_MAX,
  parameter int unsigned Y_MAX = FB_Y_MAX
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           advance,
  output logic [X_W-1:0] cx,
  output logic [Y_W-1:0] cy,
  output logic           last_c
);

  localparam logic [X_W-1:0] X_LAST = X_W'(X_MAX);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(Y_MAX);

  assign last_c = (cx == X_LAST) && (cy == Y_LAST);

  // Wrap to the origin after the final pixel so the next sweep needs no start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cx <= '0;
      cy <= '0;
    end else if (start) begin
      cx <= '0;
      cy <= '0;
    end else if (advance) begin
      if (last_c) begin
        cx <= '0;
        cy <= '0;
      end else if (cy == Y_LAST) begin
        cy <= '0;
        cx <= cx + X_W'(1);
      end else begin
        cy <= cy + Y_W'(1);
      end
    end
  end

endmodule

// File: rtl/fb_write_arbiter.sv
// Frame-buffer port A write scheduler: round-robin between two plotters,
// with a full-screen clear sweep that takes priority.
module fb_write_arbiter
  import fb_pkg::*;
#(
  parameter int unsigned      X_W        = FB_X_W,
  parameter int unsigned      Y_W        = FB_Y_W,
  parameter int unsigned      PIX_W      = FB_PIX_W,
  parameter int unsigned      X_MAX      = FB_X_MAX,
  parameter int unsigned      Y_MAX      = FB_Y_MAX,
  parameter logic [PIX_W-1:0] CLEAR_CODE = CODE_WHITE
) (
  input  logic             VGA_CTRL_CLK,
  input  logic             reset,
  input  logic             clear_req,
  output logic             clear_busy,
  input  logic             req0_valid,
  input  logic [X_W-1:0]   req0_x,
  input  logic [Y_W-1:0]   req0_y,
  input  logic [PIX_W-1:0] req0_code,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [X_W-1:0]   req1_x,
  input  logic [Y_W-1:0]   req1_y,
  input  logic [PIX_W-1:0] req1_code,
  output logic             req1_ready,
  output logic [X_W-1:0]   wr_x,
  output logic [Y_W-1:0]   wr_y,
  output logic [PIX_W-1:0] wr_data,
  output logic             wr_en,
  output logic [7:0]       oob_count
);

  localparam logic [X_W-1:0] X_LAST = X_W'(X_MAX);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(Y_MAX);

  logic [0:0]       state;
  logic [0:0]       next_state;
  logic             last_grant;
  logic             grant;
  logic             arb_open;
  logic             xfer;
  logic             oob;
  logic [X_W-1:0]   sel_x;
  logic [Y_W-1:0]   sel_y;
  logic [PIX_W-1:0] sel_code;
  logic             clr_start;
  logic             clr_adv;
  logic             clr_last;
  logic [X_W-1:0]   cx;
  logic [Y_W-1:0]   cy;
  logic             wr_en_d;
  logic [X_W-1:0]   wr_x_d;
  logic [Y_W-1:0]   wr_y_d;
  logic [PIX_W-1:0] wr_data_d;

  fb_clear_counter #(
    .X_W   (X_W),
    .Y_W   (Y_W),
    .X_MAX (X_MAX),
    .Y_MAX (Y_MAX)
  ) u_clear_counter (
    .clk     (VGA_CTRL_CLK),
    .rst     (reset),
    .start   (clr_start),
    .advance (clr_adv),
    .cx      (cx),
    .cy      (cy),
    .last_c  (clr_last)
  );

  always_ff @(posedge VGA_CTRL_CLK or posedge reset) begin
    if (reset) state <= ST_ARB;
    else       state <= next_state;
  end

  // Next state, grant, handshake and next write-port values.
  always_comb begin
    next_state = state;
    clr_start  = 1'b0;
    clr_adv    = 1'b0;
    wr_en_d    = 1'b0;
    wr_x_d     = wr_x;
    wr_y_d     = wr_y;
    wr_data_d  = wr_data;

    // With both valid, serve the one not granted last; otherwise the valid one.
    grant      = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
    arb_open   = (state == ST_ARB) && !clear_req;
    req0_ready = arb_open && !grant;
    req1_ready = arb_open && grant;
    xfer       = (req0_valid && req0_ready) || (req1_valid && req1_ready);
    sel_x      = grant ? req1_x    : req0_x;
    sel_y      = grant ? req1_y    : req0_y;
    sel_code   = grant ? req1_code : req0_code;
    oob        = (sel_x > X_LAST) || (sel_y > Y_LAST);

    case (state)
      ST_ARB: begin
        if (clear_req) begin
          next_state = ST_CLEAR;
          clr_start  = 1'b1;
        end else if (xfer && !oob) begin
          wr_en_d   = 1'b1;
          wr_x_d    = sel_x;
          wr_y_d    = sel_y;
          wr_data_d = sel_code;
        end
      end
      ST_CLEAR: begin
        clr_adv   = 1'b1;
        wr_en_d   = 1'b1;
        wr_x_d    = cx;
        wr_y_d    = cy;
        wr_data_d = CLEAR_CODE;
        if (clr_last) next_state = ST_ARB;
      end
      default: next_state = ST_ARB;
    endcase
  end

  always_ff @(posedge VGA_CTRL_CLK or posedge reset) begin
    if (reset) begin
      wr_en   <= 1'b0;
      wr_x    <= '0;
      wr_y    <= '0;
      wr_data <= '0;
    end else begin
      wr_en   <= wr_en_d;
      wr_x    <= wr_x_d;
      wr_y    <= wr_y_d;
      wr_data <= wr_data_d;
    end
  end

  assign clear_busy = (state == ST_CLEAR);

  // Pointer moves only on a completed handshake; reset favours req0.
  always_ff @(posedge VGA_CTRL_CLK or posedge reset) begin
    if (reset) begin
      last_grant <= 1'b1;
      oob_count  <= 8'd0;
    end else if (xfer) begin
      last_grant <= grant;
      if (oob && (oob_count != 8'hFF)) oob_count <= oob_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Self-checking bench for fb_write_arbiter: vector table plus clear/reset sequences.
module tb_fb_write_arbiter;

  localparam int unsigned TB_X_MAX   = 15;
  localparam int unsigned TB_Y_MAX   = 479;
  localparam int unsigned CLR_CYCLES = (TB_X_MAX + 1) * (TB_Y_MAX + 1);
  localparam int unsigned NV         = 11;

  logic       clk = 1'b0;
  logic       reset;
  logic       clear_req;
  logic       clear_busy;
  logic       req0_valid, req1_valid;
  logic [9:0] req0_x, req1_x;
  logic [8:0] req0_y, req1_y;
  logic [1:0] req0_code, req1_code;
  logic       req0_ready, req1_ready;
  logic [9:0] wr_x;
  logic [8:0] wr_y;
  logic [1:0] wr_data;
  logic       wr_en;
  logic [7:0] oob_count;

  int checks   = 0;
  int failures = 0;

  fb_write_arbiter #(
    .X_MAX (TB_X_MAX),
    .Y_MAX (TB_Y_MAX)
  ) dut (
    .VGA_CTRL_CLK (clk),
    .reset        (reset),
    .clear_req    (clear_req),
    .clear_busy   (clear_busy),
    .req0_valid   (req0_valid),
    .req0_x       (req0_x),
    .req0_y       (req0_y),
    .req0_code    (req0_code),
    .req0_ready   (req0_ready),
    .req1_valid   (req1_valid),
    .req1_x       (req1_x),
    .req1_y       (req1_y),
    .req1_code    (req1_code),
    .req1_ready   (req1_ready),
    .wr_x         (wr_x),
    .wr_y         (wr_y),
    .wr_data      (wr_data),
    .wr_en        (wr_en),
    .oob_count    (oob_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       v0;
    logic [9:0] x0;
    logic [8:0] y0;
    logic [1:0] c0;
    logic       v1;
    logic [9:0] x1;
    logic [8:0] y1;
    logic [1:0] c1;
    logic       er0;
    logic       er1;
    logic       ewe;
    logic [9:0] ex;
    logic [8:0] ey;
    logic [1:0] ed;
    logic [7:0] eoob;
  } vec_t;

  vec_t vecs [NV];

  function automatic vec_t mk(
    input logic v0, input int x0, input int y0, input int c0,
    input logic v1, input int x1, input int y1, input int c1,
    input logic er0, input logic er1, input logic ewe,
    input int ex, input int ey, input int ed, input int eoob);
    vec_t v;
    v.v0 = v0; v.x0 = 10'(x0); v.y0 = 9'(y0); v.c0 = 2'(c0);
    v.v1 = v1; v.x1 = 10'(x1); v.y1 = 9'(y1); v.c1 = 2'(c1);
    v.er0 = er0; v.er1 = er1; v.ewe = ewe;
    v.ex = 10'(ex); v.ey = 9'(ey); v.ed = 2'(ed); v.eoob = 8'(eoob);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, want);
    end
  endtask

  int  nwr;
  int  bad_data;
  int  bad_ready;
  int  bad_we;
  bit  done;
  logic [9:0] lx;
  logic [8:0] ly;

  initial begin
    //              v0 x0  y0  c0  v1 x1   y1   c1  r0 r1 we  ex  ey  ed oob
    vecs[0]  = mk(0,  0,  0, 0,  0,  0,   0, 0,  1, 0, 0,  0,  0, 0, 0);
    vecs[1]  = mk(1, 10, 20, 1,  0,  0,   0, 0,  1, 0, 1, 10, 20, 1, 0);
    vecs[2]  = mk(1,  1,  2, 1,  1,  3,   4, 2,  0, 1, 1,  3,  4, 2, 0);
    vecs[3]  = mk(1,  1,  2, 1,  1,  3,   4, 2,  1, 0, 1,  1,  2, 1, 0);
    vecs[4]  = mk(1,  1,  2, 1,  1,  3,   4, 2,  0, 1, 1,  3,  4, 2, 0);
    vecs[5]  = mk(1,  1,  2, 1,  1,  3,   4, 2,  1, 0, 1,  1,  2, 1, 0);
    vecs[6]  = mk(0,  0,  0, 0,  0,  0,   0, 0,  1, 0, 0,  1,  2, 1, 0);
    vecs[7]  = mk(0,  0,  0, 0,  1, 700,  5, 3,  0, 1, 0,  1,  2, 1, 1);
    vecs[8]  = mk(0,  0,  0, 0,  1,  5, 480, 3,  0, 1, 0,  1,  2, 1, 2);
    vecs[9]  = mk(0,  0,  0, 0,  1, 15, 479, 3,  0, 1, 1, 15, 479, 3, 2);
    vecs[10] = mk(1, 16,  0, 2,  0,  0,   0, 0,  1, 0, 0, 15, 479, 3, 3);

    reset = 1'b1; clear_req = 1'b0;
    req0_valid = 1'b0; req0_x = '0; req0_y = '0; req0_code = '0;
    req1_valid = 1'b0; req1_x = '0; req1_y = '0; req1_code = '0;
    #12;
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_x", wr_x, 0);
    chk("rst_wr_y", wr_y, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_clear_busy", clear_busy, 0);
    chk("rst_oob", oob_count, 0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      req0_valid = vecs[i].v0; req0_x = vecs[i].x0; req0_y = vecs[i].y0; req0_code = vecs[i].c0;
      req1_valid = vecs[i].v1; req1_x = vecs[i].x1; req1_y = vecs[i].y1; req1_code = vecs[i].c1;
      #1;
      chk($sformatf("v%0d_ready0", i), req0_ready, vecs[i].er0);
      chk($sformatf("v%0d_ready1", i), req1_ready, vecs[i].er1);
      @(posedge clk); #1;
      chk($sformatf("v%0d_wr_en", i), wr_en, vecs[i].ewe);
      chk($sformatf("v%0d_wr_x", i), wr_x, vecs[i].ex);
      chk($sformatf("v%0d_wr_y", i), wr_y, vecs[i].ey);
      chk($sformatf("v%0d_wr_data", i), wr_data, vecs[i].ed);
      chk($sformatf("v%0d_oob", i), oob_count, vecs[i].eoob);
    end

    // Flood of out-of-range pixels: counter must saturate, no writes.
    bad_we = 0;
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_x = 10'd700; req0_y = 9'd0; req0_code = 2'b01;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      if (wr_en) bad_we++;
    end
    chk("oob_flood_no_write", bad_we, 0);
    chk("oob_saturate", oob_count, 255);

    // Clear sweep with req0 waiting.
    clear_req = 1'b1;
    req0_x = 10'd2; req0_y = 9'd3; req0_code = 2'b01;
    #1;
    chk("clr_ready0_at_req", req0_ready, 0);
    @(posedge clk); #1;
    chk("clr_busy_rise", clear_busy, 1);
    chk("clr_no_write_first", wr_en, 0);
    clear_req = 1'b0;
    nwr = 0; bad_data = 0; bad_ready = 0; done = 1'b0; lx = '0; ly = '0;
    for (int i = 0; i < int'(CLR_CYCLES) + 50 && !done; i++) begin
      if (clear_busy && req0_ready) bad_ready++;
      @(posedge clk); #1;
      if (wr_en) begin
        nwr++;
        if (wr_data !== 2'b00) bad_data++;
        if (nwr == 1)   begin chk("clr_addr1_x", wr_x, 0); chk("clr_addr1_y", wr_y, 0); end
        if (nwr == 2)   begin chk("clr_addr2_x", wr_x, 0); chk("clr_addr2_y", wr_y, 1); end
        if (nwr == 481) begin chk("clr_addr481_x", wr_x, 1); chk("clr_addr481_y", wr_y, 0); end
        lx = wr_x; ly = wr_y;
      end
      if (!clear_busy) done = 1'b1;
    end
    chk("clr_finished", done, 1);
    chk("clr_write_count", nwr, CLR_CYCLES);
    chk("clr_last_x", lx, TB_X_MAX);
    chk("clr_last_y", ly, TB_Y_MAX);
    chk("clr_data_all_white", bad_data, 0);
    chk("clr_ready0_held_low", bad_ready, 0);
    chk("clr_ready0_first_arb", req0_ready, 1);
    @(posedge clk); #1;
    chk("post_clr_wr_en", wr_en, 1);
    chk("post_clr_wr_x", wr_x, 2);
    chk("post_clr_wr_y", wr_y, 3);
    chk("post_clr_wr_data", wr_data, 1);
    req0_valid = 1'b0;

    // Async reset in the middle of a sweep.
    clear_req = 1'b1;
    @(posedge clk); #1;
    clear_req = 1'b0;
    repeat (1000) @(posedge clk);
    #3;
    chk("mid_clr_wr_en", wr_en, 1);
    reset = 1'b1;
    #1;
    chk("arst_wr_en", wr_en, 0);
    chk("arst_busy", clear_busy, 0);
    chk("arst_oob", oob_count, 0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("arst_release_busy", clear_busy, 0);
    chk("arst_release_ready0", req0_ready, 1);
    clear_req = 1'b1;
    @(posedge clk); #1;
    clear_req = 1'b0;
    chk("reclr_busy", clear_busy, 1);
    @(posedge clk); #1;
    chk("reclr_wr_en", wr_en, 1);
    chk("reclr_x0", wr_x, 0);
    chk("reclr_y0", wr_y, 0);
    @(posedge clk); #1;
    chk("reclr_y1", wr_y, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
